// File: rtl/uart_pkg.sv
// Shared UART types: parity selection (common with the PISO transmitter) and receiver states.
package uart_pkg;

  typedef enum logic [1:0] {
    NOPARITY00 = 2'b00,
    ODD        = 2'b01,
    EVEN       = 2'b10,
    NOPARITY11 = 2'b11
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  function automatic logic has_parity(parity_t t);
    return (t == ODD) || (t == EVEN);
  endfunction

  // ones_odd is the XOR over data bits and the received parity bit.
  function automatic logic parity_err(parity_t t, logic ones_odd);
    case (t)
      ODD:     return ~ones_odd;
      EVEN:    return ones_odd;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sipo_if.sv
// Line-side and host-side signals of the UART receiver.
interface uart_rx_sipo_if #(
  parameter int DATA_W = 8
);
  logic              data_rx;
  logic [1:0]        parity_type;
  logic [DATA_W-1:0] data_out;
  logic              active_flag;
  logic              done_flag;
  logic              parity_error;
  logic              framing_error;

  modport master (
    output data_rx, parity_type,
    input  data_out, active_flag, done_flag, parity_error, framing_error
  );

  modport slave (
    input  data_rx, parity_type,
    output data_out, active_flag, done_flag, parity_error, framing_error
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a falling-edge detector; all flops reset to idle (1).
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rx_s_o,
  output logic fall_o
);
  // sync_q[0]: metastability flop, sync_q[1]: rx_s, sync_q[2]: previous rx_s
  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 3'b111;
    else        sync_q <= {sync_q[1:0], d_i};
  end

  assign rx_s_o = sync_q[1];
  assign fall_o = ~sync_q[1] & sync_q[2];
endmodule

// File: rtl/uart_rx_sipo.sv
// Oversampling UART receiver: start/data/optional parity/stop, mid-bit sampling, registered result + done pulse.
module uart_rx_sipo
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_W     = 8
) (
  input  logic          baud_clk,
  input  logic          reset_n,
  uart_rx_sipo_if.slave bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [TW-1:0] T_MID = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_END = BW'(DATA_W - 1);

  logic rx_s, fall;

  uart_rx_sync u_sync (
    .clk    (baud_clk),
    .rst_n  (reset_n),
    .d_i    (bus.data_rx),
    .rx_s_o (rx_s),
    .fall_o (fall)
  );

  rx_state_t         state_q;
  parity_t           ptype_q;
  logic [TW-1:0]     tick_q;
  logic [BW-1:0]     bit_q;
  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] dout_q;
  logic              perr_q, perr_out_q, ferr_q, active_q, done_q;
  logic              perr_d;

  assign perr_d = parity_err(ptype_q, ^{shreg_q, rx_s});

  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ptype_q    <= NOPARITY00;
      tick_q     <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      dout_q     <= '0;
      perr_q     <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_q     <= 1'b0;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (fall) begin
          state_q  <= START;
          tick_q   <= '0;
          bit_q    <= '0;
          perr_q   <= 1'b0;
          active_q <= 1'b1;
          ptype_q  <= parity_t'(bus.parity_type);
        end
        // A start bit that is high again at its midpoint is a glitch.
        START: if (tick_q == T_MID) begin
          tick_q <= '0;
          if (!rx_s) state_q <= DATA;
          else begin
            state_q  <= IDLE;
            active_q <= 1'b0;
          end
        end else tick_q <= tick_q + 1'b1;
        DATA: if (tick_q == T_END) begin
          tick_q  <= '0;
          shreg_q <= {rx_s, shreg_q[DATA_W-1:1]};
          bit_q   <= bit_q + 1'b1;
          if (bit_q == B_END) begin
            bit_q   <= '0;
            state_q <= has_parity(ptype_q) ? PARITY : STOP;
          end
        end else tick_q <= tick_q + 1'b1;
        PARITY: if (tick_q == T_END) begin
          tick_q  <= '0;
          perr_q  <= perr_d;
          state_q <= STOP;
        end else tick_q <= tick_q + 1'b1;
        // Leaving at mid stop bit lets a back-to-back start bit be caught.
        STOP: if (tick_q == T_END) begin
          tick_q     <= '0;
          dout_q     <= shreg_q;
          ferr_q     <= ~rx_s;
          perr_out_q <= perr_q;
          done_q     <= 1'b1;
          active_q   <= 1'b0;
          state_q    <= IDLE;
        end else tick_q <= tick_q + 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.data_out      = dout_q;
  assign bus.active_flag   = active_q;
  assign bus.done_flag     = done_q;
  assign bus.parity_error  = perr_out_q;
  assign bus.framing_error = ferr_q;
endmodule

// File: tb/tb_uart_rx_sipo.sv
// Directed and randomized frames for uart_rx_sipo, checked against a frame-level reference model.
module tb_uart_rx_sipo;
  localparam int OS = 16;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   t0 = 0;
  int   act_bad = 0;

  typedef struct {
    int         c;
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } done_t;
  done_t dq[$];

  uart_rx_sipo_if #(.DATA_W(DW)) bus ();

  uart_rx_sipo #(.OVERSAMPLE(OS), .DATA_W(DW)) dut (
    .baud_clk (clk),
    .reset_n  (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (bus.done_flag === 1'b1)
      dq.push_back('{cyc, bus.data_out, bus.parity_error, bus.framing_error});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_perr(logic [1:0] pt, logic [7:0] b, logic p);
    int n;
    n = $countones(b) + int'(p);
    if (pt == 2'b01) return (n % 2) == 0;
    if (pt == 2'b10) return (n % 2) == 1;
    return 1'b0;
  endfunction

  function automatic int model_lat(logic [1:0] pt);
    int p;
    p = (pt == 2'b01 || pt == 2'b10) ? 1 : 0;
    return (1 + DW + p) * OS + OS/2 + 2;
  endfunction

  task automatic drive_bit(input logic v);
    bus.data_rx = v;
    repeat (OS) @(negedge clk);
  endtask

  // Called at a negedge; t0 is the first posedge that samples the start bit.
  task automatic send_frame(input logic [7:0] b, input logic [1:0] pt, input logic pbit, input logic stop);
    bus.parity_type = pt;
    t0 = cyc + 1;
    act_bad = 0;
    drive_bit(1'b0);
    bus.parity_type = 2'($urandom);
    for (int i = 0; i < DW; i++) begin
      drive_bit(b[i]);
      if (bus.active_flag !== 1'b1) act_bad++;
    end
    if (pt == 2'b01 || pt == 2'b10) begin
      drive_bit(pbit);
      if (bus.active_flag !== 1'b1) act_bad++;
    end
    drive_bit(stop);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] b, input logic [1:0] pt,
                             input logic pbit, input logic stop);
    done_t e;
    chk({tag, ".done_cnt"}, dq.size(), 1);
    chk({tag, ".active"}, act_bad, 0);
    if (dq.size() > 0) begin
      e = dq.pop_front();
      chk({tag, ".data"}, e.d, b);
      chk({tag, ".perr"}, e.pe, model_perr(pt, b, pbit));
      chk({tag, ".ferr"}, e.fe, !stop);
      chk({tag, ".lat"}, e.c - t0, model_lat(pt));
    end
    dq.delete();
  endtask

  initial begin
    done_t      e1, e2;
    int         tb1;
    int         drop;
    logic       seen_hi;
    logic [7:0] rb;
    logic [1:0] rpt;
    logic       rp, rst;

    bus.data_rx = 1'b1;
    bus.parity_type = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst.data", bus.data_out, 0);
    chk("rst.active", bus.active_flag, 0);
    chk("rst.done", bus.done_flag, 0);
    chk("rst.perr", bus.parity_error, 0);
    chk("rst.ferr", bus.framing_error, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    send_frame(8'h4A, 2'b00, 1'b0, 1'b1);
    check_frame("np_4A", 8'h4A, 2'b00, 1'b0, 1'b1);
    chk("np_4A.hold", bus.data_out, 8'b01001010);
    chk("np_4A.lat154", model_lat(2'b00), 154);
    drive_bit(1'b1);

    send_frame(8'h4A, 2'b01, 1'b0, 1'b1);
    check_frame("odd_ok", 8'h4A, 2'b01, 1'b0, 1'b1);
    drive_bit(1'b1);
    send_frame(8'h4A, 2'b01, 1'b1, 1'b1);
    check_frame("odd_err", 8'h4A, 2'b01, 1'b1, 1'b1);
    chk("odd_err.hold", bus.parity_error, 1);
    drive_bit(1'b1);
    send_frame(8'h5A, 2'b10, 1'b0, 1'b1);
    check_frame("even_ok", 8'h5A, 2'b10, 1'b0, 1'b1);
    drive_bit(1'b1);

    // Stop bit low, then line held low: edge detection must not restart.
    send_frame(8'h4A, 2'b00, 1'b0, 1'b0);
    check_frame("frm", 8'h4A, 2'b00, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    chk("break.no_done", dq.size(), 0);
    chk("break.ferr_hold", bus.framing_error, 1);
    chk("break.active", bus.active_flag, 0);
    bus.data_rx = 1'b1;
    repeat (4) @(negedge clk);

    // Glitch: 4 low cycles.
    seen_hi = 1'b0;
    drop = -1;
    tb1 = cyc + 1;
    bus.data_rx = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 3) bus.data_rx = 1'b1;
      if (bus.active_flag === 1'b1) seen_hi = 1'b1;
      else if (seen_hi && drop < 0) drop = cyc - tb1;
    end
    chk("glitch.seen_active", seen_hi, 1);
    chk("glitch.idle_by_10", (drop > 0 && drop <= 10), 1);
    repeat (20) @(negedge clk);
    chk("glitch.no_done", dq.size(), 0);
    chk("glitch.data", bus.data_out, 8'h4A);
    chk("glitch.ferr", bus.framing_error, 1);
    chk("glitch.perr", bus.parity_error, 0);

    // Back-to-back frames.
    send_frame(8'h4A, 2'b00, 1'b0, 1'b1);
    send_frame(8'h5A, 2'b00, 1'b0, 1'b1);
    chk("b2b.done_cnt", dq.size(), 2);
    if (dq.size() == 2) begin
      e1 = dq.pop_front();
      e2 = dq.pop_front();
      chk("b2b.gap", e2.c - e1.c, 160);
      chk("b2b.d1", e1.d, 8'h4A);
      chk("b2b.d2", e2.d, 8'h5A);
      chk("b2b.lat2", e2.c - t0, 154);
    end
    chk("b2b.out", bus.data_out, 8'h5A);
    dq.delete();
    drive_bit(1'b1);

    send_frame(8'h4A, 2'b01, 1'b1, 1'b1);
    check_frame("pre_rst", 8'h4A, 2'b01, 1'b1, 1'b1);
    drive_bit(1'b1);

    // Reset in the middle of data bit 4.
    bus.parity_type = 2'b00;
    drive_bit(1'b0);
    rb = 8'h3C;
    for (int i = 0; i < 4; i++) drive_bit(rb[i]);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.data", bus.data_out, 0);
    chk("midrst.active", bus.active_flag, 0);
    chk("midrst.done", bus.done_flag, 0);
    chk("midrst.perr", bus.parity_error, 0);
    chk("midrst.ferr", bus.framing_error, 0);
    @(negedge clk);
    bus.data_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst.no_done", dq.size(), 0);
    send_frame(8'hA5, 2'b00, 1'b0, 1'b1);
    check_frame("post_rst", 8'hA5, 2'b00, 1'b0, 1'b1);
    drive_bit(1'b1);

    for (int k = 0; k < 8; k++) begin
      rb  = 8'($urandom);
      rpt = 2'($urandom_range(0, 3));
      rp  = 1'($urandom);
      rst = ($urandom_range(0, 3) != 0);
      send_frame(rb, rpt, rp, rst);
      check_frame($sformatf("rnd%0d", k), rb, rpt, rp, rst);
      bus.data_rx = 1'b1;
      repeat ($urandom_range(2, 20)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
